// File: rtl/parking_lot_multi.sv
// parking_lot_multi: multi-gate parking-lot occupancy counter.
//
// Each gate has an outer sensor (a) and an inner sensor (b). A car driving in
// blocks a, then both, then b, then clears. A car driving out does the
// mirror image. Every gate runs its own sequence recognizer. A shared
// arbiter turns the completed sequences into count updates and per-gate
// accept/refuse pulses. All of this happens on the edge that samples the
// final 00.
//
// Ports
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   a, b   [NGATES]   : outer / inner beam blocked, one bit per gate
//   count  [CW]       : cars in the lot (registered)
//   full, empty       : registered flags, coherent with count
//   ent_ok, ext_ok    : per-gate one-cycle pulse, entry / exit accepted
//   ent_rej, ext_rej  : per-gate one-cycle pulse, entry refused (full) /
//                       exit refused (empty)

// Per-gate sequence recognizer. ent_done / ext_done are combinational: they
// flag that the current sample completes a sequence.
module parking_lot_gate (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic ent_done,
  output logic ext_done
);
  typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3} state_t;

  state_t state, state_nxt;
  logic [1:0] ab;

  assign ab = {a, b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    ent_done  = 1'b0;
    ext_done  = 1'b0;
    case (state)
      IDLE: case (ab)
        2'b10:   state_nxt = IN1;
        2'b01:   state_nxt = OUT1;
        default: state_nxt = IDLE;
      endcase
      IN1: case (ab)
        2'b10:   state_nxt = IN1;
        2'b11:   state_nxt = IN2;
        default: state_nxt = IDLE;
      endcase
      IN2: case (ab)
        2'b11:   state_nxt = IN2;
        2'b01:   state_nxt = IN3;
        2'b10:   state_nxt = IN1;    // car backing out toward the street
        default: state_nxt = IDLE;
      endcase
      IN3: case (ab)
        2'b01:   state_nxt = IN3;
        2'b11:   state_nxt = IN2;
        2'b00:   ent_done  = 1'b1;   // back to IDLE and report the entry
        default: state_nxt = IDLE;   // 10: jump to a non-neighbour, drop it
      endcase
      OUT1: case (ab)
        2'b01:   state_nxt = OUT1;
        2'b11:   state_nxt = OUT2;
        default: state_nxt = IDLE;
      endcase
      OUT2: case (ab)
        2'b11:   state_nxt = OUT2;
        2'b10:   state_nxt = OUT3;
        2'b01:   state_nxt = OUT1;
        default: state_nxt = IDLE;
      endcase
      OUT3: case (ab)
        2'b10:   state_nxt = OUT3;
        2'b11:   state_nxt = OUT2;
        2'b00:   ext_done  = 1'b1;
        default: state_nxt = IDLE;
      endcase
      default: state_nxt = IDLE;
    endcase
  end
endmodule

module parking_lot_multi #(
  parameter  int NGATES = 2,
  parameter  int CAP    = 7,
  localparam int CW     = $clog2(CAP + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NGATES-1:0] a,
  input  logic [NGATES-1:0] b,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic [NGATES-1:0] ent_ok,
  output logic [NGATES-1:0] ext_ok,
  output logic [NGATES-1:0] ent_rej,
  output logic [NGATES-1:0] ext_rej
);
  // One extra bit so that count - exits + entries never overflows mid-sum.
  localparam logic [CW:0] CAP_W = (CW + 1)'(CAP);
  localparam logic [CW:0] ONE   = (CW + 1)'(1);

  logic [NGATES-1:0] ent_done, ext_done;
  logic [NGATES-1:0] ent_ok_n, ext_ok_n, ent_rej_n, ext_rej_n;
  logic [CW:0]       gx, ge, cnt_w;
  logic [CW-1:0]     count_n;

  parking_lot_gate u_gate [NGATES-1:0] (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .ent_done (ent_done),
    .ext_done (ext_done)
  );

  // Exits are resolved first, so a simultaneous exit frees a slot for an
  // entry at a full lot. Within each class, lower gate index wins.
  always_comb begin
    gx        = '0;
    ge        = '0;
    cnt_w     = {1'b0, count};
    ent_ok_n  = '0;
    ext_ok_n  = '0;
    ent_rej_n = '0;
    ext_rej_n = '0;
    for (int g = 0; g < NGATES; g++) begin
      if (ext_done[g]) begin
        if (gx < cnt_w) begin
          ext_ok_n[g] = 1'b1;
          gx          = gx + ONE;
        end else begin
          ext_rej_n[g] = 1'b1;
        end
      end
    end
    for (int g = 0; g < NGATES; g++) begin
      if (ent_done[g]) begin
        if (cnt_w - gx + ge < CAP_W) begin
          ent_ok_n[g] = 1'b1;
          ge          = ge + ONE;
        end else begin
          ent_rej_n[g] = 1'b1;
        end
      end
    end
    count_n = CW'(cnt_w - gx + ge);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      ent_ok  <= '0;
      ext_ok  <= '0;
      ent_rej <= '0;
      ext_rej <= '0;
    end else begin
      count   <= count_n;
      full    <= ({1'b0, count_n} == CAP_W);
      empty   <= (count_n == '0);
      ent_ok  <= ent_ok_n;
      ext_ok  <= ext_ok_n;
      ent_rej <= ent_rej_n;
      ext_rej <= ext_rej_n;
    end
  end
endmodule
